// File: rtl/uart_rx_ovs.sv
// UART receiver with oversampled, majority-voted bit recovery.
// Runs on the system clock. An internal tick generator divides it to OVERSAMPLE
// ticks per bit. The parity mode is latched per frame. The received word is
// handed off on a valid/ready port that reports overruns.
module uart_rx_ovs #(
    parameter int SYSCLK_RATE = 100000000,
    parameter int BAUD_RATE   = 9600,
    parameter int OVERSAMPLE  = 16,
    parameter int DATA_BITS   = 8,
    parameter int STOP_BITS   = 2,
    parameter bit MSB_FIRST   = 1'b1
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Rx,
    input  logic [1:0]           Parity_Mode,
    output logic [DATA_BITS-1:0] Data_Out,
    output logic [2:0]           Rx_Error,
    output logic                 Data_Valid,
    input  logic                 Data_Ready,
    output logic                 Overrun,
    output logic                 Rx_Busy,
    output logic                 RTS
);

    localparam int DIV   = SYSCLK_RATE / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OS_W  = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_BREAK  = 3'd5;

    if (DIV < 1) begin : g_bad_div
        $error("uart_rx_ovs: SYSCLK_RATE too low for BAUD_RATE * OVERSAMPLE");
    end
    if ((OVERSAMPLE < 8) || (OVERSAMPLE % 2 != 0)) begin : g_bad_os
        $error("uart_rx_ovs: OVERSAMPLE must be even and at least 8");
    end
    if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_data
        $error("uart_rx_ovs: DATA_BITS must be 5..9");
    end
    if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_stop
        $error("uart_rx_ovs: STOP_BITS must be 1 or 2");
    end

    logic                 rx_meta, rxs, rxs_prev;
    logic [DIV_W-1:0]     div_cnt;
    logic [OS_W-1:0]      os_cnt;
    logic [2:0]           state_q, state_d;
    logic [1:0]           par_mode_q;
    logic [DATA_BITS-1:0] shreg, shift_next;
    logic [BIT_W-1:0]     bit_cnt;
    logic                 stop_cnt;
    logic                 s_a, s_b;
    logic                 par_bit_q, par_err_q, stop_err_q, brk_q;
    logic                 fall, tick, samp_a, samp_b, vote_pt, bit_end, vote;
    logic                 par_en, par_exp, last_data, last_stop;
    logic                 brk_first, frame_brk, restart, frame_done;

    // Two-flop synchroniser plus one delayed copy for falling-edge detection.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            rx_meta  <= 1'b1;
            rxs      <= 1'b1;
            rxs_prev <= 1'b1;
        end else begin
            rx_meta  <= Rx;
            rxs      <= rx_meta;
            rxs_prev <= rxs;
        end
    end

    assign fall = rxs_prev & ~rxs;

    // Free-running baud-tick divider. It is re-phased whenever the FSM restarts bit timing.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            div_cnt <= '0;
        end else if (restart || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    assign tick = (div_cnt == DIV_W'(DIV - 1));

    // Tick position within the current bit. The tick that moves os_cnt to k is tick k.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            os_cnt <= '0;
        end else if (restart) begin
            os_cnt <= '0;
        end else if (tick) begin
            os_cnt <= (os_cnt == OS_W'(OVERSAMPLE - 1)) ? '0 : os_cnt + OS_W'(1);
        end
    end

    // Samples land on ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
    // The third sample is taken live at the vote point.
    assign samp_a  = tick && (os_cnt == OS_W'(OVERSAMPLE / 2 - 2));
    assign samp_b  = tick && (os_cnt == OS_W'(OVERSAMPLE / 2 - 1));
    assign vote_pt = tick && (os_cnt == OS_W'(OVERSAMPLE / 2));
    assign bit_end = tick && (os_cnt == OS_W'(OVERSAMPLE - 1));
    assign vote    = (s_a & s_b) | (s_a & rxs) | (s_b & rxs);

    assign par_en    = (par_mode_q == 2'b01) || (par_mode_q == 2'b10);
    assign par_exp   = (par_mode_q == 2'b10) ? ~(^shreg) : ^shreg;
    assign last_data = (bit_cnt == BIT_W'(DATA_BITS - 1));
    assign last_stop = (stop_cnt == 1'(STOP_BITS - 1));

    // Break is decided on the first stop bit. With two stop bits it is carried forward.
    assign brk_first = (shreg == '0) && !(par_en && par_bit_q) && !vote;
    assign frame_brk = (stop_cnt == 1'b0) ? brk_first : brk_q;

    // The first received bit ends up in the MSB when MSB_FIRST is set, otherwise in the LSB.
    always_comb begin
        if (MSB_FIRST) begin
            shift_next = {shreg[DATA_BITS-2:0], vote};
        end else begin
            shift_next = {vote, shreg[DATA_BITS-1:1]};
        end
    end

    // Frame sequencing: next state, timing restart and frame-completion strobe.
    always_comb begin
        state_d    = state_q;
        restart    = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (fall) begin
                    state_d = S_START;
                    restart = 1'b1;
                end
            end
            S_START: begin
                if (vote_pt && vote) begin
                    state_d = S_IDLE;
                end else if (bit_end) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end && last_data) begin
                    state_d = par_en ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                // The frame ends at the last stop bit's vote. The rest of that bit is not waited for.
                if (vote_pt && last_stop) begin
                    frame_done = 1'b1;
                    if (frame_brk) begin
                        state_d = S_BREAK;
                        restart = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_BREAK: begin
                // Any low sample restarts the one-bit-period high qualification.
                if (!rxs) begin
                    restart = 1'b1;
                end else if (bit_end) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Per-frame datapath: vote samples, shift register, counters and error flags.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            s_a        <= 1'b1;
            s_b        <= 1'b1;
            par_mode_q <= 2'b00;
            shreg      <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            par_bit_q  <= 1'b0;
            par_err_q  <= 1'b0;
            stop_err_q <= 1'b0;
            brk_q      <= 1'b0;
        end else begin
            if (samp_a) begin
                s_a <= rxs;
            end
            if (samp_b) begin
                s_b <= rxs;
            end
            case (state_q)
                S_IDLE: begin
                    if (fall) begin
                        par_mode_q <= Parity_Mode;
                        bit_cnt    <= '0;
                        stop_cnt   <= 1'b0;
                        par_bit_q  <= 1'b0;
                        par_err_q  <= 1'b0;
                        stop_err_q <= 1'b0;
                        brk_q      <= 1'b0;
                    end
                end
                S_DATA: begin
                    if (vote_pt) begin
                        shreg <= shift_next;
                    end
                    if (bit_end) begin
                        bit_cnt <= bit_cnt + BIT_W'(1);
                    end
                end
                S_PARITY: begin
                    if (vote_pt) begin
                        par_bit_q <= vote;
                        par_err_q <= (vote != par_exp);
                    end
                end
                S_STOP: begin
                    if (vote_pt) begin
                        if (!vote) begin
                            stop_err_q <= 1'b1;
                        end
                        if (stop_cnt == 1'b0) begin
                            brk_q <= brk_first;
                        end
                    end
                    if (bit_end) begin
                        stop_cnt <= stop_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output holding register. A completion in the accept cycle reloads it.
    // A completion while the register is still full is dropped and flagged.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            Data_Out   <= '0;
            Rx_Error   <= 3'b000;
            Data_Valid <= 1'b0;
            Overrun    <= 1'b0;
        end else begin
            Overrun <= 1'b0;
            if (frame_done) begin
                if (!Data_Valid || Data_Ready) begin
                    Data_Out   <= frame_brk ? '0 : shreg;
                    Rx_Error   <= frame_brk ? 3'b001 : {stop_err_q | ~vote, par_err_q, 1'b0};
                    Data_Valid <= 1'b1;
                end else begin
                    Overrun <= 1'b1;
                end
            end else if (Data_Valid && Data_Ready) begin
                Data_Valid <= 1'b0;
            end
        end
    end

    assign Rx_Busy = (state_q != S_IDLE);
    assign RTS     = ~Data_Valid;

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Directed and randomized bench for uart_rx_ovs.
// 1228800 Hz / (9600 * 16) gives 8 clocks per tick and 128 clocks per bit.
module tb_uart_rx_ovs;

    localparam int BIT = 128;
    localparam int GAP = 200;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [1:0] parity_mode;
    logic [7:0] data_out;
    logic [2:0] rx_error;
    logic       data_valid;
    logic       data_ready;
    logic       overrun;
    logic       rx_busy;
    logic       rts;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0 = 0;
    int rise_cyc = 0;
    int valid_hi = 0;
    int ovr_cnt = 0;
    int rts_bad = 0;
    bit watch_rts = 1'b0;
    logic valid_prev = 1'b0;
    logic [10:0] got[$];

    uart_rx_ovs #(
        .SYSCLK_RATE(1228800),
        .BAUD_RATE  (9600),
        .OVERSAMPLE (16),
        .DATA_BITS  (8),
        .STOP_BITS  (2),
        .MSB_FIRST  (1'b1)
    ) dut (
        .Clk        (clk),
        .Rst        (rst),
        .Rx         (rx),
        .Parity_Mode(parity_mode),
        .Data_Out   (data_out),
        .Rx_Error   (rx_error),
        .Data_Valid (data_valid),
        .Data_Ready (data_ready),
        .Overrun    (overrun),
        .Rx_Busy    (rx_busy),
        .RTS        (rts)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observer: sampled just after the falling edge, well clear of the active edge.
    always @(negedge clk) begin
        #1;
        if (data_valid && data_ready) got.push_back({data_out, rx_error});
        if (overrun) ovr_cnt++;
        if (data_valid && !valid_prev) rise_cyc = cyc;
        if (data_valid) valid_hi++;
        if (watch_rts && rts !== 1'b0) rts_bad++;
        valid_prev = data_valid;
    end

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: what a correct receiver reports for the bits that were put on the line.
    function automatic logic [10:0] model(input logic [7:0] d, input logic [1:0] mode,
                                          input logic pv, input logic s0, input logic s1);
        logic pen;
        logic pexp;
        pen  = (mode == 2'b01) || (mode == 2'b10);
        pexp = (mode == 2'b10) ? ~(^d) : ^d;
        if (d == 8'h00 && (!pen || !pv) && !s0) return {8'h00, 3'b001};
        return {d, !(s0 && s1), pen && (pv != pexp), 1'b0};
    endfunction

    // One whole frame sent MSB first. glitch_bit >= 0 inverts that data bit for one clock mid-bit.
    task automatic send_frame(input logic [7:0] d, input logic par_on, input logic pv,
                              input logic s0, input logic s1, input int glitch_bit);
        rx = 1'b0;
        t0 = cyc;
        hold(BIT);
        for (int i = 7; i >= 0; i--) begin
            rx = d[i];
            if (i == glitch_bit) begin
                hold(BIT / 2);
                rx = ~d[i];
                hold(1);
                rx = d[i];
                hold(BIT / 2 - 1);
            end else begin
                hold(BIT);
            end
        end
        if (par_on) begin
            rx = pv;
            hold(BIT);
        end
        rx = s0;
        hold(BIT);
        rx = s1;
        hold(BIT);
        rx = 1'b1;
        hold(GAP);
    endtask

    task automatic expect_word(input string tag, input logic [10:0] e, input logic busy_exp);
        logic [10:0] w;
        chk({tag, "_count"}, got.size(), 1);
        if (got.size() > 0) begin
            w = got.pop_front();
            chk({tag, "_data"}, w[10:3], e[10:3]);
            chk({tag, "_err"}, w[2:0], e[2:0]);
        end
        got.delete();
        chk({tag, "_busy"}, rx_busy, busy_exp);
    endtask

    logic [7:0] d;
    logic [1:0] m;
    logic       pv, s0, s1, pen;
    int         mid;

    initial begin
        rst         = 1'b0;
        rx          = 1'b1;
        parity_mode = 2'b00;
        data_ready  = 1'b1;
        hold(3);
        chk("rst_data", data_out, 0);
        chk("rst_err", rx_error, 0);
        chk("rst_valid", data_valid, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_busy", rx_busy, 0);
        chk("rst_rts", rts, 1);
        rst = 1'b1;
        hold(GAP);

        // Even parity, A5, with a check on delivery timing and pulse width.
        parity_mode = 2'b01;
        valid_hi    = 0;
        send_frame(8'hA5, 1'b1, ^8'hA5, 1'b1, 1'b1, -1);
        mid = t0 + BIT * 11 + BIT / 2;
        chk("a5_dv_time", (rise_cyc >= mid) && (rise_cyc <= mid + 20), 1);
        chk("a5_dv_width", valid_hi, 1);
        expect_word("a5", model(8'hA5, 2'b01, ^8'hA5, 1'b1, 1'b1), 1'b0);

        // Odd parity with the wrong and then the right parity bit.
        parity_mode = 2'b10;
        send_frame(8'hAA, 1'b1, 1'b0, 1'b1, 1'b1, -1);
        expect_word("odd_bad", {8'hAA, 3'b010}, 1'b0);
        send_frame(8'hAA, 1'b1, 1'b1, 1'b1, 1'b1, -1);
        expect_word("odd_good", {8'hAA, 3'b000}, 1'b0);

        // Both stop bits low.
        parity_mode = 2'b00;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        expect_word("stop_err", {8'h3C, 3'b100}, 1'b0);

        // Line held low for 20 bit times, then released.
        parity_mode = 2'b01;
        rx = 1'b0;
        hold(20 * BIT);
        expect_word("break", {8'h00, 3'b001}, 1'b1);
        rx = 1'b1;
        hold(100);
        chk("break_busy_hold", rx_busy, 1);
        hold(60);
        chk("break_busy_done", rx_busy, 0);
        hold(GAP);

        // 40-clock low glitch is a false start.
        parity_mode = 2'b00;
        rx = 1'b0;
        hold(40);
        rx = 1'b1;
        hold(10);
        chk("glitch_busy_start", rx_busy, 1);
        hold(150);
        chk("glitch_busy_end", rx_busy, 0);
        chk("glitch_no_word", got.size(), 0);

        // Single-clock glitches inside data bits are voted out.
        send_frame(8'hB7, 1'b0, 1'b0, 1'b1, 1'b1, 5);
        expect_word("vote_b7", {8'hB7, 3'b000}, 1'b0);
        send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 1'b1, 4);
        expect_word("vote_c3", {8'hC3, 3'b000}, 1'b0);

        // Randomized frames checked against the model.
        for (int k = 0; k < 12; k++) begin
            d   = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            m   = 2'($urandom_range(0, 3));
            pen = (m == 2'b01) || (m == 2'b10);
            pv  = (m == 2'b10) ? ~(^d) : ^d;
            if ($urandom_range(0, 4) == 0) pv = ~pv;
            s0  = ($urandom_range(0, 5) != 0);
            s1  = ($urandom_range(0, 5) != 0);
            parity_mode = m;
            send_frame(d, pen, pv, s0, s1, -1);
            expect_word($sformatf("rand%0d", k), model(d, m, pv, s0, s1), 1'b0);
        end

        // Consumer stalled: the second word overruns.
        parity_mode = 2'b00;
        data_ready  = 1'b0;
        ovr_cnt     = 0;
        send_frame(8'h11, 1'b0, 1'b0, 1'b1, 1'b1, -1);
        chk("ovr_first_valid", data_valid, 1);
        rts_bad   = 0;
        watch_rts = 1'b1;
        send_frame(8'h22, 1'b0, 1'b0, 1'b1, 1'b1, -1);
        watch_rts = 1'b0;
        chk("ovr_hold_data", data_out, 8'h11);
        chk("ovr_pulses", ovr_cnt, 1);
        chk("ovr_rts_low", rts_bad, 0);
        data_ready = 1'b1;
        hold(2);
        chk("ovr_valid_clr", data_valid, 0);
        chk("ovr_rts_high", rts, 1);
        expect_word("ovr_drain", {8'h11, 3'b000}, 1'b0);

        // Reset asserted in the middle of a frame.
        rx = 1'b0;
        hold(BIT);
        for (int i = 7; i >= 4; i--) begin
            rx = d[0];
            rx = (8'h5A >> i) & 8'h01;
            hold(BIT);
        end
        rx = 1'b1;
        hold(BIT / 2);
        chk("midrst_busy_before", rx_busy, 1);
        rst = 1'b0;
        hold(2);
        chk("midrst_data", data_out, 0);
        chk("midrst_err", rx_error, 0);
        chk("midrst_valid", data_valid, 0);
        chk("midrst_ovr", overrun, 0);
        chk("midrst_busy", rx_busy, 0);
        chk("midrst_rts", rts, 1);
        hold(5);
        rst = 1'b1;
        hold(GAP);
        chk("midrst_no_word", got.size(), 0);
        send_frame(8'h7E, 1'b0, 1'b0, 1'b1, 1'b1, -1);
        expect_word("after_rst", {8'h7E, 3'b000}, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_ovs.md
Name: uart_rx_ovs

Overview:
- Next-generation UART receiver for the UART core. It replaces the single-sample, baud-clocked receive path.
- Runs on the system clock with an internal baud-tick generator and N-times oversampling with 3-sample majority vote.
- Parity mode is runtime-selectable, stop-bit count is parametrised, and output uses a valid/ready handshake with overrun detection.
- Sits between the Rx pin synchroniser and the receive FIFO; drives RTS flow control.

Parameters:
- SYSCLK_RATE, 100000000, system clock frequency in Hz.
- BAUD_RATE, 9600, line rate in bit/s.
- OVERSAMPLE, 16, ticks per bit. Must be even and ≥ 8.
- DATA_BITS, 8, data bits per frame, range 5..9.
- STOP_BITS, 2, stop bits checked, range 1..2.
- MSB_FIRST, 1, 1 = first data bit on the line is Data_Out[DATA_BITS-1]; 0 = LSB first.

Ports:
- Clk  in  1  system clock.
- Rst  in  1  asynchronous active-low reset.
- Rx  in  1  serial line, asynchronous, idle high.
- Parity_Mode  in  2  00 = none, 01 = even, 10 = odd, 11 = none. Latched at start-bit detect.
- Data_Out  out  DATA_BITS  received word.
- Rx_Error  out  3  [0] break, [1] parity, [2] frame. Valid with Data_Valid.
- Data_Valid  out  1  word available.
- Data_Ready  in  1  consumer accepts word.
- Overrun  out  1  one-clock pulse: completed frame dropped.
- Rx_Busy  out  1  frame reception in progress.
- RTS  out  1  high when the output register is empty (= ~Data_Valid).

Behaviour:
- Reset (Rst low, async):
  - Data_Out = 0, Rx_Error = 0, Data_Valid = 0, Overrun = 0, Rx_Busy = 0, RTS = 1.
  - Synchroniser flops = 1, FSM = IDLE, tick counter = 0.
  - Reset mid-frame discards the partial frame with no output.
- Synchroniser: 2-flop on Rx. All logic uses the synchronised Rxs.
- Tick generator:
  - DIV = SYSCLK_RATE / (BAUD_RATE * OVERSAMPLE), integer; elaboration error if DIV < 1.
  - One-clock tick every DIV clocks, free-running. Counter restarts at start-bit detect so sampling is phase-aligned to the edge.
- Majority vote: per bit, sample Rxs on ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 of the bit; the bit value is the majority of the 3.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK_WAIT.
  - IDLE: on a falling edge of Rxs, go to START. Rx_Busy = 1 from the next clock. Latch Parity_Mode.
  - START: if the voted value is 1 → false start, return to IDLE, Rx_Busy = 0, no output. Otherwise go to DATA at end of bit.
  - DATA: DATA_BITS bits shifted in per MSB_FIRST. Then go to PARITY if parity is enabled, else STOP.
  - PARITY:
    - Even: expected parity bit = XOR of the data bits.
    - Odd: expected parity bit = the inverse of that XOR.
    - Mismatch sets the parity flag.
  - STOP: STOP_BITS bits. Any stop bit voted 0 sets the frame flag.
  - Frame completes at the vote point of the last stop bit; the remainder of that bit is not waited for.
  - Break: all data bits 0, parity bit 0 (if enabled) and first stop bit 0 → Rx_Error = 3'b001 (break overrides parity and frame), Data_Out = 0. Go to BREAK_WAIT; stay until Rxs = 1 for one full bit period, then IDLE.
- Delivery:
  - One clock after frame completion, load Data_Out and Rx_Error and set Data_Valid. The word is delivered even when errors are flagged.
  - Data_Valid stays high until a clock with Data_Ready = 1, then clears next clock.
  - Data_Out and Rx_Error are stable while Data_Valid = 1.
- Simultaneous accept and complete: a new frame completing in the same clock as acceptance is loaded and Data_Valid stays 1. No overrun.
- Overrun: frame completes while Data_Valid = 1 and Data_Ready = 0 → new word is dropped, the old word is held, Overrun pulses for 1 clock.
- Rx_Busy: high from the clock after start detect until return to IDLE, including BREAK_WAIT.

Test Plan:
- SYSCLK_RATE = 1228800, BAUD = 9600, OVERSAMPLE = 16 (DIV = 8, bit = 128 clocks), parity even, 2 stop bits, Data_Ready = 1. Send 8'hA5 MSB first → Data_Out = 8'hA5, Rx_Error = 0, one-clock Data_Valid pulse ~1 clock after mid-point of second stop bit.
- Parity odd. Send 8'hAA with parity bit 0 → Rx_Error = 3'b010, Data_Out = 8'hAA. Send 8'hAA with parity bit 1 → Rx_Error = 0.
- Stop bits driven 0, data 8'h3C → Rx_Error = 3'b100. Hold Rx low 20 bit times → Rx_Error = 3'b001, Data_Out = 0, Rx_Busy stays high until Rx high for 128 clocks.
- Rx low glitch of 40 clocks → no Data_Valid, Rx_Busy returns to 0. Single-clock low glitch mid-data bit → voted out, word correct.
- Data_Ready = 0. Send 8'h11 then 8'h22 → Data_Out stays 8'h11, Overrun pulses once, RTS = 0 throughout. Raise Data_Ready → Data_Valid clears, RTS = 1.
- Assert Rst low at mid-data of 8'h5A, release and send 8'h7E → no output for 8'h5A, Data_Out = 8'h7E, all outputs at reset values during reset.
